// File: rtl/uart_cpld_controller.sv
// rtl/uart_cpld_controller.sv - CPU-bus bridge to the CPLD UART: DATA/STATUS registers with timed rdn/wrn strobes.
module uart_cpld_controller #(
    parameter int PULSE_CYCLES = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_op,
    input  logic        write_op,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_data_write,
    output logic [31:0] bus_data_read,
    output logic        bus_stall,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre,
    input  logic [7:0]  uart_data_i,
    output logic [7:0]  uart_data_o,
    output logic        uart_data_oe,
    output logic        uart_active
);

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_rx_byte;
    logic [7:0]  r_tx_byte;
    logic        r_is_read;

    state_t      w_state_next;
    logic [3:0]  w_cnt_next;
    logic        w_is_data;
    logic        w_tx_ready;
    logic        w_start_rd;
    logic        w_start_wr;
    logic        w_capture;
    logic        w_stall;
    logic        w_rdn;
    logic        w_wrn;
    logic        w_oe;
    logic        w_active;
    logic [31:0] w_data_read;
    logic        w_unused_bits;

    assign w_is_data     = ~bus_addr[2];
    assign w_tx_ready    = uart_tbre & uart_tsre & (r_state == IDLE);
    assign w_unused_bits = ^{bus_addr[31:3], bus_addr[1:0], bus_data_write[31:8]};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start_rd   = 1'b0;
        w_start_wr   = 1'b0;
        w_capture    = 1'b0;
        w_stall      = 1'b0;
        w_rdn        = 1'b1;
        w_wrn        = 1'b1;
        w_oe         = 1'b0;
        w_active     = (r_state != IDLE);
        w_data_read  = 32'h0000_0000;
        case (r_state)
            IDLE: begin
                // Write wins when both ops are raised together.
                if (write_op) begin
                    w_active = w_is_data;
                    if (w_is_data) begin
                        w_stall      = 1'b1;
                        w_start_wr   = 1'b1;
                        w_state_next = WR_SETUP;
                        w_cnt_next   = SETUP_LOAD;
                    end
                end else if (read_op) begin
                    w_active = w_is_data;
                    if (!w_is_data) begin
                        w_data_read = {30'b0, uart_dataready, w_tx_ready};
                    end else if (uart_dataready) begin
                        w_stall      = 1'b1;
                        w_start_rd   = 1'b1;
                        w_state_next = RD_PULSE;
                        w_cnt_next   = PULSE_LOAD;
                    end
                end
            end
            RD_PULSE: begin
                w_stall = 1'b1;
                w_rdn   = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            WR_SETUP: begin
                w_stall = 1'b1;
                w_oe    = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = WR_PULSE;
                    w_cnt_next   = PULSE_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            WR_PULSE: begin
                w_stall = 1'b1;
                w_oe    = 1'b1;
                w_wrn   = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_state_next = WR_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            WR_HOLD: begin
                w_stall      = 1'b1;
                w_oe         = 1'b1;
                w_state_next = WR_WAIT;
            end
            WR_WAIT: begin
                w_stall = 1'b1;
                if (uart_tbre && uart_tsre) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_data_read  = r_is_read ? {24'b0, r_rx_byte} : 32'h0000_0000;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_rx_byte <= 8'h00;
            r_tx_byte <= 8'h00;
            r_is_read <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_start_wr) begin
                r_tx_byte <= bus_data_write[7:0];
                r_is_read <= 1'b0;
            end
            if (w_start_rd) begin
                r_is_read <= 1'b1;
            end
            if (w_capture) begin
                r_rx_byte <= uart_data_i;
            end
        end
    end

    assign bus_stall     = w_stall;
    assign bus_data_read = w_data_read;
    assign uart_rdn      = w_rdn;
    assign uart_wrn      = w_wrn;
    assign uart_data_oe  = w_oe;
    assign uart_data_o   = r_tx_byte;
    assign uart_active   = w_active;

endmodule

// File: doc/uart_cpld_controller.md
UART_CPLD_CONTROLLER -- requirements
Module: uart_cpld_controller

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2, meaning the width of the uart_rdn/uart_wrn low pulse in clk cycles (legal range 1..15).
REQ-002 SHALL have parameter SETUP_CYCLES, default 1, meaning the number of cycles write data is driven before uart_wrn falls (legal range 1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk  input  1  system clock (50 MHz domain); rst  input  1  reset.
REQ-004 SHALL have these CPU-bus ports: read_op  input  1  read request; write_op  input  1  write request; bus_addr  input  32  byte address, only bit 2 decoded; bus_data_write  input  32  write data, bits [7:0] used; bus_data_read  output  32  read data; bus_stall  output  1  CPU must hold its request.
REQ-005 SHALL have these CPLD-side ports: uart_rdn  output  1  read strobe, active low; uart_wrn  output  1  write strobe, active low; uart_dataready  input  1  receive byte available; uart_tbre  input  1  transmit buffer empty; uart_tsre  input  1  transmit shift register empty; uart_data_i  input  8  shared data bus in; uart_data_o  output  8  shared data bus out; uart_data_oe  output  1  drive enable for uart_data_o; uart_active  output  1  top level keeps base RAM deselected while high.

Function
REQ-006 Register map: bus_addr[2]=0 SHALL select DATA; bus_addr[2]=1 SHALL select STATUS, read-only, value {30'b0, uart_dataready, tx_ready}.
REQ-007 tx_ready SHALL be uart_tbre & uart_tsre & (state==IDLE).
REQ-008 FSM states SHALL be IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, DONE.
REQ-009 Requests SHALL be sampled only in IDLE; if read_op and write_op are both high, write SHALL win.
REQ-010 Other op/addr/data changes while state is not IDLE SHALL be ignored; the CPU holds them until bus_stall is low.
REQ-011 A STATUS read, a DATA read with uart_dataready=0, and a STATUS write SHALL complete in the same cycle in IDLE. Same-cycle behaviour: bus_stall=0; bus_data_read = status word, 0x00000000, and 0x00000000 respectively; writes have no side effect.
REQ-012 A DATA read with uart_dataready=1 in IDLE SHALL assert bus_stall combinationally and enter RD_PULSE.
REQ-013 RD_PULSE SHALL last PULSE_CYCLES cycles with uart_rdn=0.
REQ-014 At the final RD_PULSE edge, uart_data_i SHALL be captured and the FSM SHALL go to DONE.
REQ-015 A DATA write in IDLE SHALL assert bus_stall combinationally and latch bus_data_write[7:0].
REQ-016 Write sequence: WR_SETUP for SETUP_CYCLES with uart_data_oe=1 and uart_wrn=1; then WR_PULSE for PULSE_CYCLES with uart_wrn=0; then WR_HOLD for 1 cycle with uart_wrn=1 and uart_data_oe=1; then WR_WAIT with uart_data_oe=0.
REQ-017 WR_WAIT SHALL go to DONE on the first cycle where uart_tbre & uart_tsre are both 1; there is no timeout.
REQ-018 bus_stall SHALL be 1 in RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD and WR_WAIT, and 0 in DONE.
REQ-019 DONE SHALL last one cycle, then return to IDLE. In DONE, bus_data_read SHALL be {24'b0, captured byte} after a read and 0x00000000 after a write.
REQ-020 uart_active SHALL be 1 whenever state is not IDLE, and also in IDLE during any DATA-register access.
REQ-021 uart_rdn and uart_wrn SHALL never be low in the same cycle.
REQ-022 uart_data_oe SHALL never be 1 while uart_rdn=0.
REQ-023 Pulse and setup counters SHALL be 4 bits, load PARAM-1 on state entry, and decrement to 0 without wrap.

Reset
REQ-024 While rst=1 at a clk edge, the FSM SHALL go to IDLE from any state, including mid-pulse.
REQ-025 Reset values SHALL be: uart_rdn=1, uart_wrn=1, uart_data_oe=0, uart_data_o=0x00, captured byte=0x00, counters=0, bus_stall=0, bus_data_read=0x00000000, uart_active=0.
REQ-026 A request held across reset deassertion SHALL be sampled as new in the first IDLE cycle after reset.

Verification
REQ-027 STATUS read, tbre=tsre=1, dataready=1 -> same cycle: bus_data_read=0x00000003, bus_stall=0, uart_rdn stays 1.
REQ-028 DATA read, dataready=1, uart_data_i=0x5A, defaults -> bus_stall=1 at cycles 0-2; uart_rdn=0 at cycles 1-2; DONE at cycle 3 with bus_data_read=0x0000005A and bus_stall=0.
REQ-029 DATA write 0x123456C3, tbre/tsre rise at cycle 7 -> uart_data_o=0xC3; uart_data_oe=1 at cycles 1-4; uart_wrn=0 at cycles 2-3; DONE at cycle 7; bus_stall low only at cycle 7.
REQ-030 DATA read with dataready=0 -> bus_data_read=0x00000000, no stall, no rdn pulse; read_op and write_op both high -> write sequence only.
REQ-031 rst=1 in WR_PULSE cycle 2 -> next cycle: uart_wrn=1, uart_data_oe=0, bus_stall=0, state IDLE.
REQ-032 Over all scenarios, a checker SHALL flag rdn/wrn overlap or uart_data_oe=1 while uart_rdn=0.
